// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline top:
// FSM state encoding, default index width and the stall/flush bundle layout.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W_DEFAULT = 3;
  localparam int MC_CNT_W          = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_EX_BUSY = 1'b1
  } hazard_state_t;

  // Bit order of this bundle is shared with the pipeline top; do not reorder.
  typedef struct packed {
    logic f_stall;
    logic fd_stall;
    logic fd_flush;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic em_flush;
    logic mw_stall;
    logic mw_flush;
  } hazard_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: decode reads a register that the load
// currently in EX has not produced yet.
module load_use_detect #(
  parameter int REG_IDX_W = pipe_ctrl_pkg::REG_IDX_W_DEFAULT
) (
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src_a_idx,
  input  logic                 id_src_a_used,
  input  logic [REG_IDX_W-1:0] id_src_b_idx,
  input  logic                 id_src_b_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic [REG_IDX_W-1:0] ex_dst_idx,
  output logic                 load_use
);

  logic hit_a;
  logic hit_b;

  assign hit_a    = id_src_a_used && (id_src_a_idx == ex_dst_idx);
  assign hit_b    = id_src_b_used && (id_src_b_idx == ex_dst_idx);
  assign load_use = id_valid && ex_valid && ex_is_load && (hit_a || hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the F/D, D/EX, EX/M and M/WB registers,
// with multi-cycle EX tracking, a pending-redirect latch and a stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 3,
  parameter int REG_IDX_W  = REG_IDX_W_DEFAULT,
  parameter int PERF_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_src_a_idx,
  input  logic                 id_src_a_used,
  input  logic [REG_IDX_W-1:0] id_src_b_idx,
  input  logic                 id_src_b_used,
  input  logic                 ex_valid,
  input  logic                 ex_is_load,
  input  logic                 ex_multicycle,
  input  logic [REG_IDX_W-1:0] ex_dst_idx,
  input  logic                 br_redirect,
  input  logic                 m_valid,
  input  logic                 m_mem_req,
  input  logic                 m_mem_ready,
  output logic                 f_stall,
  output logic                 fd_stall,
  output logic                 fd_flush,
  output logic                 de_stall,
  output logic                 de_flush,
  output logic                 em_stall,
  output logic                 em_flush,
  output logic                 mw_stall,
  output logic                 mw_flush,
  output logic                 ctrl_busy,
  output logic [PERF_W-1:0]    stall_cycles
);

  // The first busy cycle is the start cycle itself, and the last is a release
  // cycle, so the counter covers MC_LATENCY-2 intermediate cycles.
  localparam logic [MC_CNT_W-1:0] MC_LOAD =
    (MC_LATENCY > 1) ? MC_CNT_W'(MC_LATENCY - 2) : '0;

  hazard_state_t       state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                pend_q, pend_d;
  logic [PERF_W-1:0]   stall_cnt_q;

  logic         mem_hold;
  logic         load_use;
  logic         mc_start;
  logic         mc_hold;
  logic         redir;
  hazard_ctrl_t ctrl;

  load_use_detect #(.REG_IDX_W(REG_IDX_W)) u_load_use (
    .id_valid      (id_valid),
    .id_src_a_idx  (id_src_a_idx),
    .id_src_a_used (id_src_a_used),
    .id_src_b_idx  (id_src_b_idx),
    .id_src_b_used (id_src_b_used),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_dst_idx    (ex_dst_idx),
    .load_use      (load_use)
  );

  assign mem_hold = m_valid && m_mem_req && !m_mem_ready;
  assign mc_start = (state_q == ST_IDLE) && ex_valid && ex_multicycle && (MC_LATENCY > 1);
  assign mc_hold  = mc_start || ((state_q == ST_EX_BUSY) && (mc_cnt_q != '0));
  assign redir    = br_redirect || pend_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mc_cnt_q    <= '0;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      pend_q   <= pend_d;
      if (ctrl.f_stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  // A memory wait freezes the sequencer and parks any redirect until it ends.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    pend_d   = 1'b0;
    if (mem_hold) begin
      pend_d = pend_q || br_redirect;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mc_start && !redir) begin
            state_d  = ST_EX_BUSY;
            mc_cnt_d = MC_LOAD;
          end
        end
        ST_EX_BUSY: begin
          if (redir || (mc_cnt_q == '0)) begin
            state_d  = ST_IDLE;
            mc_cnt_d = '0;
          end else begin
            mc_cnt_d = mc_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          mc_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    if (!rst) begin
      ctrl = '0;
    end else if (mem_hold) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_stall = 1'b1;
      ctrl.em_stall = 1'b1;
      ctrl.mw_flush = 1'b1;
    end else if (redir) begin
      ctrl.fd_flush = 1'b1;
      ctrl.de_flush = 1'b1;
    end else if (mc_hold) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_stall = 1'b1;
      ctrl.em_flush = 1'b1;
    end else if (load_use) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_flush = 1'b1;
    end
  end

  assign f_stall      = ctrl.f_stall;
  assign fd_stall     = ctrl.fd_stall;
  assign fd_flush     = ctrl.fd_flush;
  assign de_stall     = ctrl.de_stall;
  assign de_flush     = ctrl.de_flush;
  assign em_stall     = ctrl.em_stall;
  assign em_flush     = ctrl.em_flush;
  assign mw_stall     = ctrl.mw_stall;
  assign mw_flush     = ctrl.mw_flush;
  assign ctrl_busy    = rst && ((state_q == ST_EX_BUSY) || pend_q);
  assign stall_cycles = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 4-register in-order pipeline: F/D, D/EX, EX/M and M/WB.
- Drives every pipeline register's stall and flush inputs from four events:
  - load-use hazards seen at decode
  - multi-cycle EX operations
  - memory-stage wait states
  - branch redirects resolved in EX
- Holds a one-entry pending-redirect latch, a multi-cycle occupancy counter and a saturating stall-cycle performance counter.

Parameters:
- MC_LATENCY, 3, number of cycles a multi-cycle op occupies EX (legal range 1..15).
- REG_IDX_W, 3, register index width; must match the dst_idx width in the pipeline registers.
- PERF_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- id_valid  in  1  decode stage holds a valid instruction.
- id_src_a_idx  in  REG_IDX_W  decode source A index.
- id_src_a_used  in  1  source A is read.
- id_src_b_idx  in  REG_IDX_W  decode source B index.
- id_src_b_used  in  1  source B is read.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_multicycle  in  1  EX instruction is a multi-cycle op.
- ex_dst_idx  in  REG_IDX_W  EX destination index.
- br_redirect  in  1  single-cycle pulse: taken/mispredicted branch resolved in EX.
- m_valid  in  1  M stage holds a valid instruction.
- m_mem_req  in  1  M instruction accesses memory.
- m_mem_ready  in  1  memory completes this cycle.
- f_stall  out  1  hold fetch PC.
- fd_stall, fd_flush  out  1 each  F/D register controls.
- de_stall, de_flush  out  1 each  D/EX register controls.
- em_stall, em_flush  out  1 each  EX/M register controls.
- mw_stall, mw_flush  out  1 each  M/WB register controls.
- ctrl_busy  out  1  FSM in EX_BUSY or redirect pending.
- stall_cycles  out  PERF_W  saturating count of cycles with f_stall=1.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, mc_cnt=0, pend_redir=0, stall_cycles=0. All stall/flush outputs and ctrl_busy are forced 0 while rst=0, regardless of inputs.
- Derived terms (combinational, same cycle):
  - mem_hold = m_valid & m_mem_req & ~m_mem_ready
  - load_use = id_valid & ex_valid & ex_is_load & ((id_src_a_used & a==ex_dst_idx) | (id_src_b_used & b==ex_dst_idx))
  - mc_start = (state==IDLE) & ex_valid & ex_multicycle & (MC_LATENCY>1)
  - mc_hold = mc_start | (state==EX_BUSY & mc_cnt!=0)
  - redir = br_redirect | pend_redir
- Output priority; exactly one row applies and all unlisted outputs are 0:
  1. mem_hold: f_stall, fd_stall, de_stall, em_stall = 1; mw_flush = 1.
  2. redir: fd_flush, de_flush = 1. Overrides load_use and mc_hold.
  3. mc_hold: f_stall, fd_stall, de_stall = 1; em_flush = 1.
  4. load_use: f_stall, fd_stall = 1; de_flush = 1.
- mw_stall is never asserted; it is tied 0 and the port is kept for uniformity.
- FSM has two states, IDLE and EX_BUSY.
  - IDLE -> EX_BUSY on mc_start & ~mem_hold & ~redir; load mc_cnt = MC_LATENCY-2.
  - EX_BUSY, mc_cnt!=0, ~mem_hold: decrement mc_cnt.
  - EX_BUSY, mc_cnt==0: release cycle, no stall; go to IDLE.
  - mem_hold in any state freezes state and mc_cnt.
  - redir while in EX_BUSY is a protocol violation. Redirect wins, FSM goes to IDLE and mc_cnt is cleared.
  - Result: a multi-cycle op spends exactly MC_LATENCY cycles in EX and produces MC_LATENCY-1 stall cycles. MC_LATENCY=1 never stalls.
  - Back-to-back multi-cycle ops: the next op starts from IDLE on the cycle after release.
- Pending redirect:
  - br_redirect & mem_hold sets pend_redir (row 1 wins that cycle).
  - pend_redir is consumed, and its flushes emitted, on the first cycle with ~mem_hold, then cleared.
  - br_redirect arriving while pend_redir=1 merges; only one flush pair is emitted.
- stall_cycles increments on every clk with f_stall=1 and saturates at all-ones without wrapping.
- ctrl_busy = (state==EX_BUSY) | pend_redir.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (IDLE=0, EX_BUSY=1)
  - the REG_IDX_W default
  - the stall/flush bundle bit ordering, reused by the pipeline top.
- One sub-module: load_use_detect, a purely combinational comparator producing load_use.

Test Plan:
1. Reset mid-EX_BUSY: assert rst=0 with mc_cnt=1 -> all outputs 0 immediately, state=IDLE, stall_cycles=0 after release.
2. Load-use: ex_is_load=1, ex_dst_idx=4, id_src_b_idx=4, used=1 -> one cycle of f_stall=fd_stall=de_flush=1. Same stimulus with id_src_b_used=0 -> no stall.
3. Multi-cycle, MC_LATENCY=3: ex_multicycle=1 -> f_stall/de_stall/em_flush high for exactly 2 cycles, released on the 3rd. A second op immediately after -> 2 more stall cycles.
4. Memory wait: m_mem_req=1, m_mem_ready=0 for 4 cycles -> em_stall=mw_flush=1 for 4 cycles. Then ready=1 -> all 0 and stall_cycles=4.
5. Redirect during mem wait: br_redirect pulse in wait cycle 2 of 3 -> no flush during the wait; fd_flush=de_flush=1 on the first cycle after ready; ctrl_busy=1 during pendency.
6. Priority: load_use and br_redirect in the same cycle -> only fd_flush/de_flush=1, f_stall=0. With PERF_W=4, 20 stall cycles -> stall_cycles=15.
